// File: rtl/press_flasher_pkg.sv
// Shared types and constants for the press_flasher LED pulse stretcher.
package press_flasher_pkg;

   typedef enum logic [1:0] {IDLE, ON, OFF} state_e;

   localparam int unsigned CLK_HZ = 5_000_000;

   function automatic int unsigned ms_to_cycles(input int unsigned ms);
      return (CLK_HZ / 1000) * ms;
   endfunction

   localparam int unsigned DEF_ON_CYCLES  = ms_to_cycles(200);
   localparam int unsigned DEF_OFF_CYCLES = ms_to_cycles(200);

endpackage

// File: rtl/flash_timer.sv
// Loadable down-counter with zero flag; holds at zero, never wraps.
module flash_timer #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/press_flasher.sv
// Turns single-cycle event pulses into fixed-length LED flashes with a saturating queue.
// Optional sticky drop flag port ovf when PRESS_FLASHER_OVF_EN is defined.
module press_flasher
   import press_flasher_pkg::*;
#(
   parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
   parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
   parameter int unsigned PEND_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              evt,
   output logic              led,
   output logic              busy,
   output logic [PEND_W-1:0] pending
`ifdef PRESS_FLASHER_OVF_EN
   ,
   output logic              ovf
`endif
);

   localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   state_e            state_q, state_d;
   logic              led_q, led_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              start, accept;
   logic              t_load, t_zero;
   logic [TW-1:0]     t_val;

   flash_timer #(
      .W(TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (t_val),
      .zero     (t_zero)
   );

   always_comb begin
      start  = ((state_q == IDLE) || (state_q == OFF && t_zero)) &&
               (evt || pending_q != '0);
      // A full queue can still take an event when a start frees a slot this cycle.
      accept = evt && !(pending_q == PEND_MAX && !start);
      pending_d = pending_q + PEND_W'(accept) - PEND_W'(start);

      state_d = state_q;
      t_load  = 1'b0;
      t_val   = ON_LOAD;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ON;
               t_load  = 1'b1;
            end
         end
         ON: begin
            if (t_zero) begin
               state_d = OFF;
               t_load  = 1'b1;
               t_val   = OFF_LOAD;
            end
         end
         OFF: begin
            if (t_zero) begin
               if (start) begin
                  state_d = ON;
                  t_load  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      led_d = (state_d == ON);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         led_q     <= 1'b0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         led_q     <= led_d;
         pending_q <= pending_d;
      end
   end

   assign led     = led_q;
   assign busy    = (state_q != IDLE);
   assign pending = pending_q;

`ifdef PRESS_FLASHER_OVF_EN
   logic ovf_q, ovf_d;

   assign ovf_d = ovf_q | (evt & ~accept);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_press_flasher.sv
// Self-checking bench for press_flasher: timeline model of flashes plus directed literal checks.
module tb_press_flasher;

   localparam int ON   = 4;
   localparam int OFF  = 3;
   localparam int PW   = 2;
   localparam int PMAX = 3;

   logic          clk;
   logic          rst;
   logic          evt;
   logic          led;
   logic          busy;
   logic [PW-1:0] pending;
`ifdef PRESS_FLASHER_OVF_EN
   logic          ovf;
`endif

   press_flasher #(
      .ON_CYCLES  (ON),
      .OFF_CYCLES (OFF),
      .PEND_W     (PW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .evt     (evt),
      .led     (led),
      .busy    (busy),
      .pending (pending)
`ifdef PRESS_FLASHER_OVF_EN
      ,
      .ovf     (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model: a flash is described only by the edge at which it started.
   int edge_n = 0;
   int fs     = 0;
   bit fs_v   = 1'b0;
   int m_pend = 0;
   bit m_led  = 1'b0;
   bit m_busy = 1'b0;
   bit m_ovf  = 1'b0;

   logic          s_led, s_busy;
   logic [PW-1:0] s_pend;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      fs_v   = 1'b0;
      m_pend = 0;
      m_led  = 1'b0;
      m_busy = 1'b0;
      m_ovf  = 1'b0;
   endtask

   task automatic model_step(input bit e);
      int age;
      bit can, st, acc;
      if (!rst) return;
      edge_n++;
      age = edge_n - 1 - fs;
      can = !fs_v || age >= ON + OFF - 1;
      st  = can && (e || m_pend != 0);
      acc = e && !(m_pend == PMAX && !st);
      m_pend = m_pend + int'(acc) - int'(st);
      if (e && !acc) m_ovf = 1'b1;
      if (st) begin
         fs   = edge_n;
         fs_v = 1'b1;
      end
      m_led  = fs_v && (edge_n - fs) < ON;
      m_busy = fs_v && (edge_n - fs) < ON + OFF;
   endtask

   // Drive at negedge, model at posedge, sample at the following negedge.
   task automatic cyc(input bit e);
      evt = e;
      @(posedge clk);
      model_step(e);
      @(negedge clk);
      s_led  = led;
      s_busy = busy;
      s_pend = pending;
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b0;
      #1;
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);
      model_reset();
      cyc(1'b0);
      cyc(1'b0);
      rst = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("led", 32'(led), 32'(m_led));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("pending", 32'(pending), 32'(m_pend));
`ifdef PRESS_FLASHER_OVF_EN
         chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
   end

   initial begin
      logic [7:0]  lt8, bt8;
      logic [19:0] lt20;
      int          pend_or, rises, dens;
      logic        prev_led, stay_low;

      rst = 1'b0;
      evt = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_led", 32'(led), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_pend", 32'(pending), 32'd0);
      rst    = 1'b1;
      chk_en = 1'b1;
      repeat (3) cyc(1'b0);

      // Single event from idle
      pend_or = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(i == 0);
         lt8[i] = s_led;
         bt8[i] = s_busy;
         pend_or = pend_or | int'(s_pend);
      end
      chk("single_led_trace", 32'(lt8), 32'h0F);
      chk("single_busy_trace", 32'(bt8), 32'h7F);
      chk("single_pend", 32'(pend_or), 32'd0);
      repeat (3) cyc(1'b0);

      // Three consecutive events
      for (int i = 0; i < 20; i++) begin
         cyc(i < 3);
         lt20[i] = s_led;
         if (i == 0) chk("three_pend_e1", 32'(s_pend), 32'd0);
         if (i == 1) chk("three_pend_e2", 32'(s_pend), 32'd1);
         if (i == 2) chk("three_pend_e3", 32'(s_pend), 32'd2);
         if (i == 6) chk("three_pend_e7", 32'(s_pend), 32'd2);
         if (i == 7) chk("three_pend_e8", 32'(s_pend), 32'd1);
         if (i == 14) chk("three_pend_e15", 32'(s_pend), 32'd0);
      end
      chk("three_led_trace", 32'(lt20), 32'h3C78F);
      repeat (5) cyc(1'b0);

      // Five events saturate a depth-3 queue
      rises    = 0;
      prev_led = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cyc(i < 5);
         if (s_led && !prev_led) rises++;
         prev_led = s_led;
         if (i == 3) chk("sat_pend_e4", 32'(s_pend), 32'd3);
         if (i == 4) chk("sat_pend_e5", 32'(s_pend), 32'd3);
`ifdef PRESS_FLASHER_OVF_EN
         if (i == 3) chk("sat_ovf_before", 32'(ovf), 32'd0);
         if (i == 4) chk("sat_ovf_after", 32'(ovf), 32'd1);
         if (i == 39) chk("sat_ovf_sticky", 32'(ovf), 32'd1);
`endif
      end
      chk("sat_flash_count", 32'(rises), 32'd4);

      // Event on the last OFF cycle restarts with no idle gap
      cyc(1'b1);
      repeat (5) cyc(1'b0);
      cyc(1'b0);
      chk("lastoff_busy_e7", 32'(s_busy), 32'd1);
      chk("lastoff_led_e7", 32'(s_led), 32'd0);
      cyc(1'b1);
      chk("lastoff_led_e8", 32'(s_led), 32'd1);
      chk("lastoff_pend_e8", 32'(s_pend), 32'd0);
      repeat (10) cyc(1'b0);

      // Asynchronous reset mid-flash with a queue
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b1);
      chk("midrst_pend_pre", 32'(s_pend), 32'd2);
      chk("midrst_led_pre", 32'(s_led), 32'd1);
      do_reset();
      stay_low = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0);
         stay_low = stay_low | s_led | s_busy;
      end
      chk("midrst_no_restart", 32'(stay_low), 32'd0);
      cyc(1'b1);
      chk("midrst_new_led", 32'(s_led), 32'd1);
      repeat (10) cyc(1'b0);

      // Randomized traffic with varying density and occasional resets
      dens = 20;
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) begin
            case ($urandom_range(0, 3))
               0:       dens = 3;
               1:       dens = 15;
               2:       dens = 45;
               default: dens = 90;
            endcase
         end
         cyc($urandom_range(0, 99) < dens);
         if ($urandom_range(0, 599) == 0) do_reset();
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
